probe_value_multi: RTL and testbench
====================================

# probe_value_multi

Multi-channel, buffered successor to the single-value probe. It watches `NumChannels` probe inputs on the emulation clock and queues each value change in a per-channel FIFO of `Depth` entries. Queued samples are serialized onto the shared 32-bit uplink as header+data packets under round-robin arbitration. It sits between user-design probe points and the serial probe transport, decoding the same 19-bit command downlink.

## Interface
Parameters:
- `ProbeIdBase`, 0: probe id of channel 0; channel i answers to `ProbeIdBase+i` (16-bit, wraps mod 2^16).
- `ProbeWidth`, 1: bits per channel sample, 1..256.
- `NumChannels`, 4: number of channels, 1..8.
- `Depth`, 4: FIFO entries per channel, a power of 2 in 2..16.
- `InitiallyEnabled`, 0: `NumChannels`-bit enable mask loaded on reset.

Ports:
- `UCLK` in 1: single clock; probe inputs are sampled on it too.
- `URST` in 1: reset, synchronous, active-high.
- `CMDEN` in 1: command strobe.
- `CMD` in 19: [18:3] probe id, [2:0] opcode.
- `PROBEIN` in `NumChannels*ProbeWidth`: channel i occupies [i*ProbeWidth +: ProbeWidth].
- `PROBEEN` in `NumChannels`: per-channel sample-valid.
- `DATAUP` out 32: uplink word.
- `DATAVALID` out 1: `DATAUP` is valid.
- `ACK` in 1: uplink consumed the current word.
- `DELAY` out 1: backpressure request to stall the emulation clock.
- `OVERRUN` out `NumChannels`: sticky per-channel drop flag.

## Operation
- Opcodes: 0 DISABLE, 2 ENABLE (plus forced send), 5 SENDONCE, 6 CLROVR. Other opcodes, and ids outside the channel range, are ignored.
- Per channel state: `last` (`ProbeWidth`, reset 0), `enabled`, `once`, `force`, FIFO, `drops` (8-bit, saturates at 255), `OVERRUN`.
- Change detect: if `PROBEEN[i]` and `PROBEIN_i != last`, then `last <= PROBEIN_i`. This happens whether or not the channel is enabled.
- A change push happens when a change is detected and `enabled` is set. The value pushed is `PROBEIN_i`.
- ENABLE sets `enabled=1`, `once=0`, `force=1`. SENDONCE sets `enabled=1`, `once=1`. DISABLE clears `enabled`, `once` and `force`. CLROVR clears `OVERRUN[i]` and `drops`.
- Forced push: if `force` is set, the cycle after the command pushes `last`, then `force` clears. If a change push occurs in the same cycle, exactly one push is made, carrying the new value.
- After any successful push with `once` set, clear both `enabled` and `once`.
- Push to a full FIFO: drop the sample, set `OVERRUN[i]`, increment `drops` (saturating).
- Serializer FSM has states IDLE, HDR and DATA.
  - IDLE: when at least one FIFO is non-empty, grant round-robin starting after the last granted channel. Pop the head into `shift`. Load header `{id[15:0], drops[7:0], ProbeWords[7:0]}`. Clear `drops`, except that a drop in the same cycle leaves it at 1. Go to HDR.
  - HDR and DATA: `DATAVALID=1`. ACK moves to the next word, sending `shift[31:0]` and shifting right by 32.
  - After `ProbeWords` data words, the final ACK returns the FSM to IDLE.
- `ProbeWords = ceil(ProbeWidth/32)`. Data goes least-significant word first. The top word is zero-padded.
- `DELAY` = OR over channels of (FIFO count ≥ `Depth-1`).

## Timing
- Reset values:
  - `DATAVALID=0`, `DATAUP=0`, `DELAY=0`, `OVERRUN=0`.
  - All FIFOs empty, `last=0`, `drops=0`.
  - `enabled=InitiallyEnabled`, `force=0`, `once=0`.
  - FSM in IDLE; round-robin pointer set so channel 0 is granted first.
- Reset taken mid-packet aborts the packet: `DATAVALID=0` from the next cycle and all queued samples are discarded.
- Latency: a change sampled at edge t is in the FIFO after t. The FSM grants at t+1. Header appears with `DATAVALID=1` after edge t+1, i.e. during cycle t+2.
- A command at edge t takes effect after edge t. A forced push happens at t+1, so its header is visible in cycle t+3 when the FSM is idle.
- `ACK` is ignored while `DATAVALID=0`. `DATAUP` holds steady until ACKed and updates on the edge where `ACK` is high.
- There is one IDLE cycle between consecutive packets.
- Push and pop of the same FIFO in the same cycle are both honoured. A pop from a full FIFO frees a slot, so a simultaneous push is not dropped.

## Structure
- Shared package `probe_pkg` holds:
  - opcode constants `PDISABLE`=0, `PENABLE`=2, `PSENDONCE`=5 (must agree with the transport's enable-mode encoding), `PCLROVR`=6;
  - the header-packing function;
  - the `ProbeWords` calculation.
- Sub-module `probe_sample_fifo`: parameters `Width` and `Depth`; a synchronous FIFO with full/empty flags and an occupancy count. Instantiate it once per channel in a generate loop.

## Test plan
- Width 8, `ProbeIdBase=0x10`; enable channel 1, then drive `PROBEEN[1]` with `PROBEIN_1=0xA5` -> header `0x0011_0001`, then data `0x0000_00A5`, then `DATAVALID=0`.
- `ProbeWidth=40`, value `0xAB_1234_5678` -> header `...0002`, then data `0x1234_5678`, then `0x0000_00AB`.
- `Depth=4`, `ACK` held low, 6 changes on channel 0 -> `DELAY=1` once the FIFO holds 3 entries, `OVERRUN[0]=1`, and the next header carries drops=1 (4 queued, 1 in the serializer, 1 dropped).
- SENDONCE on channel 2, then two changes `0x01` and `0x02` -> only the `0x01` packet is sent and `enabled[2]` reads 0 afterwards.
- All 4 channels change in the same cycle -> packets arrive in order ch0, ch1, ch2, ch3. A second burst continues the rotation from ch0.
- `URST` asserted during the DATA word of a packet -> `DATAVALID=0` the next cycle, no further output, and `OVERRUN=0`.

Source files
------------

// File: rtl/probe_pkg.sv
// Shared definitions for the probe family: command opcodes, uplink header
// packing and the number of 32-bit words a probe sample occupies.
package probe_pkg;

  // Downlink opcodes; PSENDONCE matches the transport's enable-mode encoding.
  localparam logic [2:0] PDISABLE  = 3'd0;
  localparam logic [2:0] PENABLE   = 3'd2;
  localparam logic [2:0] PSENDONCE = 3'd5;
  localparam logic [2:0] PCLROVR   = 3'd6;

  // Number of 32-bit uplink words needed to carry one sample.
  function automatic int probe_words(input int width);
    return (width + 31) / 32;
  endfunction

  // Header word: probe id, drops since last packet, data word count.
  function automatic logic [31:0] pack_header(input logic [15:0] id,
                                              input logic [7:0]  drops,
                                              input logic [7:0]  words);
    return {id, drops, words};
  endfunction

endpackage

// File: rtl/probe_sample_fifo.sv
// Synchronous per-channel sample FIFO. A pop and a push in the same cycle are
// both honoured, including when the FIFO is full.
module probe_sample_fifo #(
  parameter int Width = 1,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (Depth is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Sample storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(Depth));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/probe_value_multi.sv
// Multi-channel buffered value probe. Each channel queues value changes in its
// own FIFO; a round-robin serializer sends header+data packets on the uplink.
module probe_value_multi
  import probe_pkg::*;
#(
  parameter int ProbeIdBase = 0,
  parameter int ProbeWidth  = 1,
  parameter int NumChannels = 4,
  parameter int Depth       = 4,
  parameter logic [NumChannels-1:0] InitiallyEnabled = '0
) (
  input  logic                              UCLK,
  input  logic                              URST,
  input  logic                              CMDEN,
  input  logic [18:0]                       CMD,
  input  logic [NumChannels*ProbeWidth-1:0] PROBEIN,
  input  logic [NumChannels-1:0]            PROBEEN,
  output logic [31:0]                       DATAUP,
  output logic                              DATAVALID,
  input  logic                              ACK,
  output logic                              DELAY,
  output logic [NumChannels-1:0]            OVERRUN
);

  localparam int PW  = probe_words(ProbeWidth);
  localparam int SW  = PW * 32;
  localparam int CW  = $clog2(Depth) + 1;
  localparam int CHW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]            state;
  logic [CHW-1:0]        last_grant;
  logic [CHW-1:0]        grant;
  logic                  grant_valid;
  logic                  grant_fire;
  logic [3:0]            words_left;
  logic [SW-1:0]         shift;
  logic [SW-1:0]         padded;

  logic [NumChannels-1:0] fifo_full;
  logic [NumChannels-1:0] fifo_empty;
  logic [NumChannels-1:0] fifo_pop;
  logic [ProbeWidth-1:0]  head_arr  [NumChannels];
  logic [CW-1:0]          count_arr [NumChannels];
  logic [7:0]             drops_arr [NumChannels];

  logic [15:0] cmd_off;
  logic        cmd_hit;

  // A command addresses channel (id - ProbeIdBase) mod 2^16 when in range.
  assign cmd_off = CMD[18:3] - 16'(ProbeIdBase);
  assign cmd_hit = CMDEN && ({16'd0, cmd_off} < 32'(NumChannels));

  assign grant_fire = (state == S_IDLE) && grant_valid;

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    logic [ProbeWidth-1:0] pin;
    logic [ProbeWidth-1:0] last_q;
    logic [ProbeWidth-1:0] push_val;
    logic                  en_q;
    logic                  once_q;
    logic                  force_q;
    logic                  ovr_q;
    logic [7:0]            drops_q;
    logic                  change;
    logic                  change_push;
    logic                  push_req;
    logic                  accepted;
    logic                  dropped;
    logic                  sel;

    assign pin         = PROBEIN[i*ProbeWidth +: ProbeWidth];
    assign change      = PROBEEN[i] && (pin != last_q);
    assign change_push = change && en_q;
    // A coincident change supersedes the forced resend: one push, new value.
    assign push_req    = change_push || force_q;
    assign push_val    = change_push ? pin : last_q;
    assign accepted    = push_req && (!fifo_full[i] || fifo_pop[i]);
    assign dropped     = push_req && !accepted;
    assign sel         = cmd_hit && (cmd_off[CHW-1:0] == CHW'(i));
    assign fifo_pop[i] = grant_fire && (grant == CHW'(i));

    assign OVERRUN[i]   = ovr_q;
    assign drops_arr[i] = drops_q;

    // Channel control: change tracking, one-shot/force handling, drop
    // accounting; commands are applied last so they override same-cycle events.
    always_ff @(posedge UCLK) begin
      if (URST) begin
        last_q  <= '0;
        en_q    <= InitiallyEnabled[i];
        once_q  <= 1'b0;
        force_q <= 1'b0;
        ovr_q   <= 1'b0;
        drops_q <= 8'd0;
      end else begin
        if (change) last_q <= pin;
        force_q <= 1'b0;
        if (accepted && once_q) begin
          en_q   <= 1'b0;
          once_q <= 1'b0;
        end
        if (fifo_pop[i]) begin
          drops_q <= dropped ? 8'd1 : 8'd0;
        end else if (dropped && (drops_q != 8'hFF)) begin
          drops_q <= drops_q + 8'd1;
        end
        if (dropped) ovr_q <= 1'b1;
        if (sel) begin
          case (CMD[2:0])
            PDISABLE: begin
              en_q    <= 1'b0;
              once_q  <= 1'b0;
              force_q <= 1'b0;
            end
            PENABLE: begin
              en_q    <= 1'b1;
              once_q  <= 1'b0;
              force_q <= 1'b1;
            end
            PSENDONCE: begin
              en_q   <= 1'b1;
              once_q <= 1'b1;
            end
            PCLROVR: begin
              ovr_q   <= 1'b0;
              drops_q <= 8'd0;
            end
            default: ;
          endcase
        end
      end
    end

    probe_sample_fifo #(
      .Width (ProbeWidth),
      .Depth (Depth)
    ) u_fifo (
      .clk       (UCLK),
      .rst       (URST),
      .push      (accepted),
      .push_data (push_val),
      .pop       (fifo_pop[i]),
      .head      (head_arr[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i]),
      .count     (count_arr[i])
    );
  end

  // Round-robin pick: first non-empty channel after the last one granted.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = last_grant;
    grant_valid = 1'b0;
    for (int k = 1; k <= NumChannels; k++) begin
      idx = (int'(last_grant) + k) % NumChannels;
      if (!grant_valid && !fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant       = CHW'(idx);
      end
    end
  end

  // Zero-extend the granted head sample to a whole number of uplink words.
  always_comb begin
    padded                 = '0;
    padded[ProbeWidth-1:0] = head_arr[grant];
  end

  // Backpressure once any FIFO is within one entry of full.
  always_comb begin
    DELAY = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (count_arr[c] >= CW'(Depth - 1)) DELAY = 1'b1;
    end
  end

  // Serializer FSM: grant and load header in IDLE, then step words on ACK.
  always_ff @(posedge UCLK) begin
    if (URST) begin
      state      <= S_IDLE;
      DATAVALID  <= 1'b0;
      DATAUP     <= 32'd0;
      words_left <= 4'd0;
      last_grant <= CHW'(NumChannels - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            last_grant <= grant;
            DATAUP     <= pack_header(16'(ProbeIdBase) + 16'(grant),
                                      drops_arr[grant], 8'(PW));
            DATAVALID  <= 1'b1;
            words_left <= 4'(PW);
            state      <= S_HDR;
          end
        end
        S_HDR, S_DATA: begin
          if (ACK) begin
            if (words_left == 4'd0) begin
              DATAVALID <= 1'b0;
              DATAUP    <= 32'd0;
              state     <= S_IDLE;
            end else begin
              DATAUP     <= shift[31:0];
              words_left <= words_left - 4'd1;
              state      <= S_DATA;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sample shift register: loaded on grant, advanced one word per data ACK.
  always_ff @(posedge UCLK) begin
    if (grant_fire) begin
      shift <= padded;
    end else if ((state != S_IDLE) && ACK && (words_left != 4'd0)) begin
      shift <= shift >> 32;
    end
  end

endmodule

// File: tb/tb_probe_value_multi.sv
// Directed bench for probe_value_multi: three instances cover the 8-bit
// four-channel case, a 40-bit multi-word case and an all-enabled arbiter case.
module tb_probe_value_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmden = 1'b0;
  logic [18:0] cmd = '0;
  logic        ack = 1'b0;

  logic [31:0] p8_in = '0;
  logic [3:0]  p8_en = '0;
  logic [31:0] up8;
  logic        dv8, dly8;
  logic [3:0]  ovr8;

  logic [79:0] p40_in = '0;
  logic [1:0]  p40_en = '0;
  logic [31:0] up40;
  logic        dv40, dly40;
  logic [1:0]  ovr40;

  logic [31:0] pa_in = '0;
  logic [3:0]  pa_en = '0;
  logic [31:0] upa;
  logic        dva, dlya;
  logic [3:0]  ovra;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  probe_value_multi #(.ProbeIdBase(16'h10), .ProbeWidth(8), .NumChannels(4),
                      .Depth(4), .InitiallyEnabled(4'h0)) dut (
    .UCLK(clk), .URST(rst), .CMDEN(cmden), .CMD(cmd), .PROBEIN(p8_in),
    .PROBEEN(p8_en), .DATAUP(up8), .DATAVALID(dv8), .ACK(ack), .DELAY(dly8),
    .OVERRUN(ovr8));

  probe_value_multi #(.ProbeIdBase(16'h20), .ProbeWidth(40), .NumChannels(2),
                      .Depth(4), .InitiallyEnabled(2'b00)) dut40 (
    .UCLK(clk), .URST(rst), .CMDEN(cmden), .CMD(cmd), .PROBEIN(p40_in),
    .PROBEEN(p40_en), .DATAUP(up40), .DATAVALID(dv40), .ACK(ack), .DELAY(dly40),
    .OVERRUN(ovr40));

  probe_value_multi #(.ProbeIdBase(16'h30), .ProbeWidth(8), .NumChannels(4),
                      .Depth(4), .InitiallyEnabled(4'hF)) dut_all (
    .UCLK(clk), .URST(rst), .CMDEN(cmden), .CMD(cmd), .PROBEIN(pa_in),
    .PROBEEN(pa_en), .DATAUP(upa), .DATAVALID(dva), .ACK(ack), .DELAY(dlya),
    .OVERRUN(ovra));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmden = 1'b0; ack = 1'b0;
    p8_en = '0; p40_en = '0; pa_en = '0;
    p8_in = '0; p40_in = '0; pa_in = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [15:0] id, input logic [2:0] op);
    cmden = 1'b1;
    cmd   = {id, op};
    tick();
    cmden = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (dv8 !== 1'b0) begin bad++; $display("FAIL reset_dv8 got=%0h exp=0", dv8); end
    total++; if (up8 !== 32'd0) begin bad++; $display("FAIL reset_up8 got=%08h exp=00000000", up8); end
    total++; if (dly8 !== 1'b0) begin bad++; $display("FAIL reset_delay got=%0h exp=0", dly8); end
    total++; if (ovr8 !== 4'h0) begin bad++; $display("FAIL reset_overrun got=%0h exp=0", ovr8); end
    total++; if (dv40 !== 1'b0) begin bad++; $display("FAIL reset_dv40 got=%0h exp=0", dv40); end
    total++; if (dva !== 1'b0) begin bad++; $display("FAIL reset_dva got=%0h exp=0", dva); end
  endtask

  task automatic test_basic();
    do_reset();
    send_cmd(16'h11, 3'd2);
    p8_in[15:8] = 8'hA5; p8_en = 4'b0010;
    tick();
    p8_en = 4'b0000;
    total++; if (dv8 !== 1'b0) begin bad++; $display("FAIL basic_latency got=%0h exp=0", dv8); end
    tick();
    total++; if (dv8 !== 1'b1) begin bad++; $display("FAIL basic_hdr_valid got=%0h exp=1", dv8); end
    total++; if (up8 !== 32'h0011_0001) begin bad++; $display("FAIL basic_hdr got=%08h exp=00110001", up8); end
    ack = 1'b1;
    tick();
    total++; if (up8 !== 32'h0000_00A5) begin bad++; $display("FAIL basic_data got=%08h exp=000000a5", up8); end
    tick();
    total++; if (dv8 !== 1'b0) begin bad++; $display("FAIL basic_end got=%0h exp=0", dv8); end
    ack = 1'b0;
  endtask

  task automatic test_wide();
    do_reset();
    send_cmd(16'h20, 3'd2);
    p40_in[39:0] = 40'hAB_1234_5678; p40_en = 2'b01;
    tick();
    p40_en = 2'b00;
    tick();
    total++; if (up40 !== 32'h0020_0002) begin bad++; $display("FAIL wide_hdr got=%08h exp=00200002", up40); end
    ack = 1'b1;
    tick();
    total++; if (up40 !== 32'h1234_5678) begin bad++; $display("FAIL wide_word0 got=%08h exp=12345678", up40); end
    tick();
    total++; if (up40 !== 32'h0000_00AB) begin bad++; $display("FAIL wide_word1 got=%08h exp=000000ab", up40); end
    tick();
    total++; if (dv40 !== 1'b0) begin bad++; $display("FAIL wide_end got=%0h exp=0", dv40); end
    ack = 1'b0;
  endtask

  task automatic test_sendonce();
    do_reset();
    send_cmd(16'h12, 3'd5);
    p8_in[23:16] = 8'h01; p8_en = 4'b0100;
    tick();
    p8_in[23:16] = 8'h02;
    tick();
    p8_en = 4'b0000;
    total++; if (up8 !== 32'h0012_0001) begin bad++; $display("FAIL once_hdr got=%08h exp=00120001", up8); end
    ack = 1'b1;
    tick();
    total++; if (up8 !== 32'h0000_0001) begin bad++; $display("FAIL once_data got=%08h exp=00000001", up8); end
    tick();
    ack = 1'b0;
    p8_in[23:16] = 8'h03; p8_en = 4'b0100;
    tick();
    p8_en = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      total++; if (dv8 !== 1'b0) begin bad++; $display("FAIL once_quiet[%0d] got=%0h exp=0", n, dv8); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) pa_in[c*8 +: 8] = 8'(8'hC0 + 8'(b * 16) + 8'(c));
      pa_en = 4'hF;
      tick();
      pa_en = 4'h0;
      tick();
      for (int c = 0; c < 4; c++) begin
        total++;
        if (upa !== (32'h0030_0001 | (32'(c) << 16))) begin
          bad++; $display("FAIL rr_hdr b%0d c%0d got=%08h exp=%08h", b, c, upa, 32'h0030_0001 | (32'(c) << 16));
        end
        ack = 1'b1;
        tick();
        total++;
        if (upa !== 32'(8'hC0 + 8'(b * 16) + 8'(c))) begin
          bad++; $display("FAIL rr_data b%0d c%0d got=%08h exp=%08h", b, c, upa, 32'(8'hC0 + 8'(b * 16) + 8'(c)));
        end
        tick();
        ack = 1'b0;
        tick();
      end
      total++; if (dva !== 1'b0) begin bad++; $display("FAIL rr_drained b%0d got=%0h exp=0", b, dva); end
    end
  endtask

  task automatic test_overrun_and_reset();
    do_reset();
    send_cmd(16'h10, 3'd2);
    for (int v = 1; v <= 6; v++) begin
      p8_in[7:0] = 8'(v); p8_en = 4'b0001;
      tick();
      if (v == 2) begin
        total++; if (up8 !== 32'h0010_0001) begin bad++; $display("FAIL ovr_hdr1 got=%08h exp=00100001", up8); end
      end
      if (v == 3) begin
        total++; if (dly8 !== 1'b0) begin bad++; $display("FAIL ovr_delay2 got=%0h exp=0", dly8); end
      end
      if (v == 4) begin
        total++; if (dly8 !== 1'b1) begin bad++; $display("FAIL ovr_delay3 got=%0h exp=1", dly8); end
      end
      if (v == 6) begin
        total++; if (up8 !== 32'h0010_0001) begin bad++; $display("FAIL ovr_hold got=%08h exp=00100001", up8); end
      end
    end
    p8_en = 4'b0000;
    total++; if (ovr8 !== 4'b0001) begin bad++; $display("FAIL ovr_flag got=%0h exp=1", ovr8); end
    ack = 1'b1;
    tick();
    total++; if (up8 !== 32'h0000_0001) begin bad++; $display("FAIL ovr_data1 got=%08h exp=00000001", up8); end
    tick();
    total++; if (dv8 !== 1'b0) begin bad++; $display("FAIL ovr_gap got=%0h exp=0", dv8); end
    ack = 1'b0;
    tick();
    total++; if (up8 !== 32'h0010_0101) begin bad++; $display("FAIL ovr_hdr2 got=%08h exp=00100101", up8); end
    ack = 1'b1;
    tick();
    total++; if (up8 !== 32'h0000_0002) begin bad++; $display("FAIL ovr_data2 got=%08h exp=00000002", up8); end
    ack = 1'b0;
    rst = 1'b1;
    tick();
    total++; if (dv8 !== 1'b0) begin bad++; $display("FAIL rst_dv got=%0h exp=0", dv8); end
    total++; if (ovr8 !== 4'h0) begin bad++; $display("FAIL rst_overrun got=%0h exp=0", ovr8); end
    total++; if (up8 !== 32'd0) begin bad++; $display("FAIL rst_up got=%08h exp=00000000", up8); end
    total++; if (dly8 !== 1'b0) begin bad++; $display("FAIL rst_delay got=%0h exp=0", dly8); end
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      total++; if (dv8 !== 1'b0) begin bad++; $display("FAIL rst_quiet[%0d] got=%0h exp=0", n, dv8); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_sendonce();
    test_round_robin();
    test_overrun_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
